// File: rtl/enc_pkg.sv
// Shared constants for the registered priority encoder.
// State encodings are single-bit constants so they match older netlists that use the same encoding.
package enc_pkg;
  localparam int ENC_N_DEFAULT = 32;
  localparam int ENC_W_DEFAULT = 5;
  localparam int LOST_CNT_W    = 8;

  localparam logic ENC_IDLE  = 1'b0;
  localparam logic ENC_GRANT = 1'b1;

  typedef logic [LOST_CNT_W-1:0] lost_cnt_t;
endpackage

// File: rtl/ffs_enc.sv
// Combinational find-first-set: binary index of the lowest set bit, plus an any-set flag.
module ffs_enc #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] in,
  output logic [W-1:0] code,
  output logic         any
);
  // The scan runs from the top down, so the lowest set bit is written last and wins.
  always_comb begin
    code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in[i]) code = W'(i);
    end
  end

  assign any = |in;
endmodule

// File: rtl/prio_encoder_32_5.sv
// Registered priority encoder: sticky pending bits, lowest-index grant over a valid/ack handshake.
// Optional ENC_MASK_EN adds a req_mask input that gates which pending bits the encoder searches.
module prio_encoder_32_5
  import enc_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N-1:0]          req,
`ifdef ENC_MASK_EN
  input  logic [N-1:0]          req_mask,
`endif
  input  logic                  out_ack,
  output logic                  out_valid,
  output logic [W-1:0]          out_code,
  output logic [N-1:0]          pending,
  output logic [LOST_CNT_W-1:0] lost_cnt
);
  logic         state;
  logic [N-1:0] clr;
  logic [N-1:0] pending_nxt;
  logic [N-1:0] search;
  logic         collide;
  logic [W-1:0] ffs_code;
  logic         ffs_any;

  // clr is built from the held code. A req in the same cycle is ORed in afterwards, so the set wins.
  assign clr         = (out_valid && out_ack) ? ({{(N-1){1'b0}}, 1'b1} << out_code) : '0;
  assign pending_nxt = (pending & ~clr) | req;
  assign collide     = |(req & pending & ~clr);

`ifdef ENC_MASK_EN
  assign search = pending & req_mask;
`else
  assign search = pending;
`endif

  ffs_enc #(.N(N), .W(W)) u_ffs (
    .in   (search),
    .code (ffs_code),
    .any  (ffs_any)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ENC_IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      lost_cnt  <= '0;
    end else begin
      pending <= pending_nxt;
      if (collide && (lost_cnt != {LOST_CNT_W{1'b1}})) lost_cnt <= lost_cnt + 1'b1;
      case (state)
        ENC_IDLE: begin
          if (ffs_any) begin
            out_code  <= ffs_code;
            out_valid <= 1'b1;
            state     <= ENC_GRANT;
          end
        end
        ENC_GRANT: begin
          // The granted code is held until ack. Newer requests do not preempt it.
          if (out_ack) begin
            out_valid <= 1'b0;
            state     <= ENC_IDLE;
          end
        end
        default: state <= ENC_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prio_encoder_32_5.sv
// Directed testbench for prio_encoder_32_5. Expected grant codes are queued and checked as each grant appears.
// Define ENC_MASK_EN for both the bench and the RTL to include the mask scenario.
module tb_prio_encoder_32_5;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] req;
  logic        out_ack;
  logic        out_valid;
  logic [4:0]  out_code;
  logic [31:0] pending;
  logic [7:0]  lost_cnt;
`ifdef ENC_MASK_EN
  logic [31:0] req_mask;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int w;

  always #5 clk = ~clk;

  prio_encoder_32_5 dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
`ifdef ENC_MASK_EN
    .req_mask  (req_mask),
`endif
    .out_ack   (out_ack),
    .out_valid (out_valid),
    .out_code  (out_code),
    .pending   (pending),
    .lost_cnt  (lost_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for out_valid, then compare out_code against the next queued expectation.
  task automatic wait_grant(input string tag, output int waited);
    int exp;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check({tag, "_code"}, {27'b0, out_code}, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    req     = 32'hFFFF_FFFF;
    out_ack = 1'b0;
`ifdef ENC_MASK_EN
    req_mask = 32'hFFFF_FFFF;
`endif
    repeat (3) tick();
    check("rst_pending", pending, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_code", {27'b0, out_code}, 32'd0);
    check("rst_lost", {24'b0, lost_cnt}, 32'd0);

    // Release with all lines requesting. Grants must come out 0..31, one every 2 cycles.
    resetn = 1'b1;
    tick();
    req = 32'h0;
    check("rel_t1_valid", {31'b0, out_valid}, 32'd0);
    check("rel_t1_pending", pending, 32'hFFFF_FFFF);
    tick();
    check("rel_t2_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 32; i++) exp_q.push_back(i);
    out_ack = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_grant("all_ones", w);
      if (i > 0) check("all_ones_gap", w, 32'd1);
      tick();
    end
    check("all_ones_pending", pending, 32'h0);
    check("all_ones_lost", {24'b0, lost_cnt}, 32'd0);

    // Single request, ack tied high.
    exp_q.push_back(8);
    req = 32'h0000_0100;
    tick();
    req = 32'h0;
    check("single_t1_valid", {31'b0, out_valid}, 32'd0);
    check("single_t1_pending", pending, 32'h0000_0100);
    tick();
    wait_grant("single", w);
    check("single_latency", w, 32'd0);
    tick();
    check("single_done_pending", pending, 32'h0);
    check("single_done_valid", {31'b0, out_valid}, 32'd0);

    // A later request with a higher priority does not preempt the held grant.
    out_ack = 1'b0;
    exp_q.push_back(5);
    exp_q.push_back(1);
    req = 32'h0000_0020;
    tick();
    req = 32'h0;
    tick();
    wait_grant("prio_first", w);
    check("prio_first_latency", w, 32'd0);
    tick();
    req = 32'h0000_0002;
    tick();
    req = 32'h0;
    check("prio_hold_pending", pending, 32'h0000_0022);
    repeat (3) tick();
    check("prio_hold_code", {27'b0, out_code}, 32'd5);
    check("prio_hold_valid", {31'b0, out_valid}, 32'd1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("prio_bubble_valid", {31'b0, out_valid}, 32'd0);
    wait_grant("prio_second", w);
    check("prio_second_gap", w, 32'd1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("prio_done_pending", pending, 32'h0);

    // A request for the granted bit in its own ack cycle sets the bit pending again.
    exp_q.push_back(3);
    exp_q.push_back(3);
    req = 32'h0000_0008;
    tick();
    req = 32'h0;
    wait_grant("setwin_first", w);
    out_ack = 1'b1;
    req     = 32'h0000_0008;
    tick();
    out_ack = 1'b0;
    req     = 32'h0;
    check("setwin_repend", pending, 32'h0000_0008);
    check("setwin_lost", {24'b0, lost_cnt}, 32'd0);
    wait_grant("setwin_second", w);
    check("setwin_gap", w, 32'd1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("setwin_done_pending", pending, 32'h0);

    // lost_cnt counts each colliding cycle and saturates at 255.
    req = 32'h0000_0001;
    repeat (100) tick();
    check("lost_100", {24'b0, lost_cnt}, 32'd99);
    repeat (200) tick();
    check("lost_sat", {24'b0, lost_cnt}, 32'd255);
    req = 32'h0;
    exp_q.push_back(0);
    wait_grant("lost_grant", w);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("lost_done_pending", pending, 32'h0);
    check("lost_hold", {24'b0, lost_cnt}, 32'd255);

    // An asynchronous reset during GRANT drops the grant and all pending bits at once.
    exp_q.push_back(0);
    req = 32'h0000_0011;
    tick();
    req = 32'h0;
    wait_grant("midrst_grant", w);
    resetn = 1'b0;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_pending", pending, 32'h0);
    check("midrst_lost", {24'b0, lost_cnt}, 32'd0);
    tick();
    resetn = 1'b1;
    repeat (2) tick();
    check("midrst_after_valid", {31'b0, out_valid}, 32'd0);

`ifdef ENC_MASK_EN
    // Masked bits stay pending and are granted once their mask bit is set.
    exp_q.push_back(1);
    req_mask = 32'h0000_0002;
    req      = 32'h0000_0003;
    tick();
    req = 32'h0;
    wait_grant("mask_first", w);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    repeat (3) tick();
    check("mask_blocked_valid", {31'b0, out_valid}, 32'd0);
    check("mask_blocked_pending", pending, 32'h0000_0001);
    exp_q.push_back(0);
    req_mask = 32'h0000_0003;
    wait_grant("mask_second", w);
    req_mask = 32'h0;
    repeat (2) tick();
    check("mask_hold_valid", {31'b0, out_valid}, 32'd1);
    check("mask_hold_code", {27'b0, out_code}, 32'd0);
    out_ack = 1'b1;
    tick();
    out_ack  = 1'b0;
    req_mask = 32'hFFFF_FFFF;
    check("mask_done_pending", pending, 32'h0);
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
